// File: rtl/regfile8x16_pkg.sv
// Shared constants and types for the 8-entry register file.
// Optional write-to-read bypass is selected in the top by REGFILE_BYPASS_EN.
package regfile8x16_pkg;

  localparam int unsigned RF_WIDTH = 16;
  localparam int unsigned RF_NREGS = 8;
  localparam int unsigned RF_SEL_W = 3;

  typedef logic [RF_WIDTH-1:0] rf_word_t;

endpackage

// File: rtl/regfile8x16_reg16.sv
// WIDTH-bit storage register with asynchronous active-low clear and load enable.
module reg16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) q_d = d_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/regfile8x16.sv
// 8x16 register file: two combinational read ports, one synchronous write port.
// Defining REGFILE_BYPASS_EN forwards writeData to a read port selecting the write target.
module regfile8x16
  import regfile8x16_pkg::*;
#(
  parameter int unsigned WIDTH = RF_WIDTH,
  parameter int unsigned NREGS = RF_NREGS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [RF_SEL_W-1:0] read1RegSel,
  input  logic [RF_SEL_W-1:0] read2RegSel,
  input  logic [RF_SEL_W-1:0] writeRegSel,
  input  logic [WIDTH-1:0]    writeData,
  input  logic                writeEn,
  output logic [WIDTH-1:0]    read1Data,
  output logic [WIDTH-1:0]    read2Data
);

  logic [NREGS-1:0] wr_en;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] rd1_tree, rd2_tree;

  always_comb begin
    wr_en = '0;
    if (writeEn) wr_en[writeRegSel] = 1'b1;
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_regs
    reg16 #(
      .WIDTH (WIDTH)
    ) u_reg (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .en_i   (wr_en[i]),
      .d_i    (writeData),
      .q_o    (regs[i])
    );
  end

  function automatic logic [WIDTH-1:0] mux4(input logic [1:0]       s,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c,
                                            input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] y;
    unique case (s)
      2'd0: y = a;
      2'd1: y = b;
      2'd2: y = c;
      2'd3: y = d;
    endcase
    return y;
  endfunction

  // Two 4:1 stages on sel[1:0], final 2:1 on sel[2].
  always_comb begin
    rd1_tree = read1RegSel[2] ?
               mux4(read1RegSel[1:0], regs[4], regs[5], regs[6], regs[7]) :
               mux4(read1RegSel[1:0], regs[0], regs[1], regs[2], regs[3]);
    rd2_tree = read2RegSel[2] ?
               mux4(read2RegSel[1:0], regs[4], regs[5], regs[6], regs[7]) :
               mux4(read2RegSel[1:0], regs[0], regs[1], regs[2], regs[3]);
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is gated by rst_n so outputs stay zero throughout reset.
  always_comb begin
    read1Data = rd1_tree;
    read2Data = rd2_tree;
    if (rst_n && writeEn && (writeRegSel == read1RegSel)) read1Data = writeData;
    if (rst_n && writeEn && (writeRegSel == read2RegSel)) read2Data = writeData;
  end
`else
  always_comb begin
    read1Data = rd1_tree;
    read2Data = rd2_tree;
  end
`endif

endmodule

// File: tb/tb_regfile8x16.sv
// Directed self-checking bench for regfile8x16; inputs change on negedge, sampled mid-cycle.
module tb_regfile8x16;
  import regfile8x16_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [RF_SEL_W-1:0] read1RegSel, read2RegSel, writeRegSel;
  rf_word_t            writeData;
  logic                writeEn;
  rf_word_t            read1Data, read2Data;

  int vectors = 0;
  int miscompares = 0;

  regfile8x16 #(
    .WIDTH (RF_WIDTH),
    .NREGS (RF_NREGS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .read1RegSel (read1RegSel),
    .read2RegSel (read2RegSel),
    .writeRegSel (writeRegSel),
    .writeData   (writeData),
    .writeEn     (writeEn),
    .read1Data   (read1Data),
    .read2Data   (read2Data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input rf_word_t obs, input rf_word_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rf_word_t exp_k;
    rst_n       = 1'b0;
    writeEn     = 1'b0;
    writeData   = '0;
    writeRegSel = '0;
    read1RegSel = '0;
    read2RegSel = '0;

    // Reset: every select reads zero.
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      read1RegSel = 3'(k);
      read2RegSel = 3'(7 - k);
      #1;
      check($sformatf("reset_rd1_sel%0d", k), read1Data, 16'h0000);
      check($sformatf("reset_rd2_sel%0d", 7 - k), read2Data, 16'h0000);
    end

    // Release reset, then write 0x1111*k to rk on consecutive edges.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      writeEn     = 1'b1;
      writeRegSel = 3'(k);
      writeData   = 16'(16'h1111 * k);
    end
    @(negedge clk);
    writeEn = 1'b0;

    // Sweep both ports with independent selects.
    for (int k = 0; k < 8; k++) begin
      read1RegSel = 3'(k);
      read2RegSel = 3'(7 - k);
      #1;
      exp_k = 16'(16'h1111 * k);
      check($sformatf("wr_rd1_r%0d", k), read1Data, exp_k);
      exp_k = 16'(16'h1111 * (7 - k));
      check($sformatf("wr_rd2_r%0d", 7 - k), read2Data, exp_k);
    end
    read1RegSel = 3'd2;
    read2RegSel = 3'd5;
    #1;
    check("indep_rd1_r2", read1Data, 16'h2222);
    check("indep_rd2_r5", read2Data, 16'h5555);

    // Disabled write must not disturb r3.
    @(negedge clk);
    writeEn     = 1'b0;
    writeData   = 16'hFFFF;
    writeRegSel = 3'd3;
    read1RegSel = 3'd3;
    read2RegSel = 3'd3;
    repeat (4) @(negedge clk);
    #1;
    check("noen_rd1_r3", read1Data, 16'h3333);
    check("noen_rd2_r3", read2Data, 16'h3333);

    // Same-cycle read of the register being written.
    @(negedge clk);
    writeEn     = 1'b1;
    writeRegSel = 3'd4;
    writeData   = 16'hABCD;
    read1RegSel = 3'd4;
    read2RegSel = 3'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_before_edge", read1Data, 16'hABCD);
`else
    check("same_before_edge", read1Data, 16'h4444);
`endif
    check("same_other_port", read2Data, 16'h5555);
    @(posedge clk);
    #1;
    check("same_after_edge", read1Data, 16'hABCD);

    // Back-to-back writes to r6: last one wins.
    @(negedge clk);
    writeRegSel = 3'd6;
    writeData   = 16'h1234;
    @(negedge clk);
    writeData   = 16'h5678;
    @(negedge clk);
    writeEn     = 1'b0;
    read2RegSel = 3'd6;
    #1;
    check("last_write_r6", read2Data, 16'h5678);
    check("r4_retained", read1Data, 16'hABCD);

    // Mid-operation async reset between edges.
    @(negedge clk);
    read1RegSel = 3'd4;
    read2RegSel = 3'd7;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rd1", read1Data, 16'h0000);
    check("async_rst_rd2", read2Data, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_rd2", read2Data, 16'h0000);

    // Reset priority: write edge while rst_n low is discarded.
    @(negedge clk);
    rst_n       = 1'b0;
    writeEn     = 1'b1;
    writeRegSel = 3'd2;
    writeData   = 16'hBEEF;
    read1RegSel = 3'd2;
    #1;
    check("rst_prio_during", read1Data, 16'h0000);
    @(negedge clk);
    writeEn = 1'b0;
    rst_n   = 1'b1;
    #1;
    check("rst_prio_after", read1Data, 16'h0000);

    // First write after release is a normal write.
    @(negedge clk);
    writeEn   = 1'b1;
    writeData = 16'h0F0F;
    @(negedge clk);
    writeEn = 1'b0;
    #1;
    check("first_write_after_rst", read1Data, 16'h0F0F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
